// File: rtl/uart_tx_io_if.sv
// CPU-side IO bus of the UART transmitter.
//   io_write  1-cycle strobe, push io_wdata into the transmit queue
//   io_wdata  byte to send
//   io_read   1-cycle status read strobe (clears the sticky overflow flag)
//   io_rdata  status word {28'b0, overflow, busy, empty, full}
// master = CPU / MemOrIO decoder, slave = uart_tx_io.
interface uart_tx_io_if;
  logic        io_write;
  logic [7:0]  io_wdata;
  logic        io_read;
  logic [31:0] io_rdata;

  modport master (output io_write, output io_wdata, output io_read, input io_rdata);
  modport slave  (input io_write, input io_wdata, input io_read, output io_rdata);
endinterface

// File: rtl/uart_tx_io.sv
// Memory-mapped UART transmitter, 8N1, LSB first.
// Bytes written over the IO bus are queued in a small FIFO and serialized
// on tx; software polls the status word before writing.
// Ports:
//   clock    cpu clock
//   reset    synchronous, active-low
//   bus      uart_tx_io_if.slave (io_write/io_wdata/io_read/io_rdata)
//   tx       serial line, idle high, registered
//   tx_busy  high while a frame is on the line, registered
module uart_tx_io #(
  parameter int unsigned CLKS_PER_BIT = 180,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic          clock,
  input  logic          reset,
  uart_tx_io_if.slave   bus,
  output logic          tx,
  output logic          tx_busy
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, overflow;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          baud_last;

  // full is taken before any same-cycle pop, so a write while full is dropped
  // even if IDLE frees a slot on the same edge.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = bus.io_write && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  assign bus.io_rdata = {28'd0, overflow, tx_busy, empty, full};

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.io_wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // a dropped write wins over a clearing read in the same cycle
      if (bus.io_write && full) overflow <= 1'b1;
      else if (bus.io_read)     overflow <= 1'b0;
    end
  end

  // tx/tx_busy are registered from the current state, so the line follows
  // the state by one cycle: pop at N+1, start bit on the line after N+2.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (!empty) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          tx      <= 1'b0;
          tx_busy <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          tx      <= shift[0];
          tx_busy <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) state <= S_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          tx      <= 1'b1;
          tx_busy <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Accepted bytes go into a scoreboard queue; a line monitor decodes every
// frame on tx, checks the bit-exact waveform, busy, and inter-frame gaps.
module tb_uart_tx_io;
  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic tx, tx_busy;

  uart_tx_io_if io_bus ();

  uart_tx_io #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clock   (clk),
    .reset   (rst_n),
    .bus     (io_bus),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  sb [$];
  logic        in_frame = 1'b0;
  int unsigned frames_seen = 0;

  // ---------------- line monitor ----------------
  initial begin : monitor
    logic        prev, eb, ok, aborted, have_end;
    logic [7:0]  exp_b, got;
    int unsigned cyc, end_cyc, gap;
    prev = 1'b1; have_end = 1'b0; cyc = 0; end_cyc = 0;
    forever begin
      @(negedge clk); cyc++;
      if (!rst_n) begin prev = 1'b1; have_end = 1'b0; continue; end
      if (prev && !tx) begin
        in_frame = 1'b1;
        frames_seen++;
        if (have_end) begin
          gap = cyc - end_cyc - 1;
          checks++;
          assert (gap === 1) else begin
            errors++; $error("FAIL gap: got %0d idle cycles expected 1", gap);
          end
        end
        checks++;
        assert (sb.size() > 0) else begin
          errors++; $error("FAIL unexpected_frame: got frame expected none");
        end
        exp_b = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        ok = 1'b1; aborted = 1'b0; got = '0;
        for (int i = 0; i < 10 * CPB; i++) begin
          if (i > 0) begin @(negedge clk); cyc++; end
          if (!rst_n) begin aborted = 1'b1; break; end
          if (i < CPB) eb = 1'b0;
          else if (i >= 9 * CPB) eb = 1'b1;
          else eb = exp_b[(i / CPB) - 1];
          if (tx !== eb || tx_busy !== 1'b1) ok = 1'b0;
          if (i >= CPB && i < 9 * CPB && (i % CPB) == CPB / 2) got[(i / CPB) - 1] = tx;
        end
        if (aborted) begin
          in_frame = 1'b0; prev = 1'b1; have_end = 1'b0;
          continue;
        end
        checks++;
        assert ({ok, got} === {1'b1, exp_b}) else begin
          errors++; $error("FAIL frame: got byte %h wave_ok %b expected byte %h wave_ok 1", got, ok, exp_b);
        end
        end_cyc  = cyc;
        have_end = (sb.size() > 0);
        @(negedge clk); cyc++;
        if (rst_n) begin
          checks++;
          assert ({tx, tx_busy} === 2'b10) else begin
            errors++; $error("FAIL post_stop: got tx/busy %b expected 10", {tx, tx_busy});
          end
        end
        prev = tx;
        in_frame = 1'b0;
      end else begin
        prev = tx;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    io_bus.io_write = 1'b1;
    io_bus.io_wdata = b;
    tick(1);
    io_bus.io_write = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned limit, input string tag);
    int unsigned n = 0;
    while (!(sb.size() == 0 && !in_frame && tx_busy == 1'b0) && n < limit) begin
      tick(1); n++;
    end
    checks++;
    assert (n < limit) else begin
      errors++; $error("FAIL %s: got timeout after %0d cycles expected drain", tag, n);
    end
    tick(2);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin : stim
    int unsigned n, fs;
    rst_n = 1'b0;
    io_bus.io_write = 1'b0;
    io_bus.io_wdata = '0;
    io_bus.io_read  = 1'b0;

    // 1. reset
    tick(3);
    check32("reset_tx", {31'd0, tx}, 32'h1);
    check32("reset_busy", {31'd0, tx_busy}, 32'h0);
    check32("reset_status", io_bus.io_rdata, 32'h2);
    rst_n = 1'b1;
    tick(2);

    // 2. single byte A5, latency of empty/pop/start bit
    sb.push_back(8'hA5);
    wr(8'hA5);
    check32("lat_empty_clear", io_bus.io_rdata, 32'h0);
    tick(1);
    check32("lat_popped", io_bus.io_rdata, 32'h2);
    check32("lat_tx_idle", {31'd0, tx}, 32'h1);
    tick(1);
    check32("lat_tx_start", {31'd0, tx}, 32'h0);
    check32("lat_busy", io_bus.io_rdata, 32'h6);
    wait_idle(200, "drain_a5");

    // 3/4. fill the FIFO (first pop happens during the second write), overflow
    for (int b = 0; b < 9; b++) begin
      sb.push_back(8'(b));
      wr(8'(b));
    end
    check32("fifo_full", io_bus.io_rdata, 32'h5);
    wr(8'hFF);
    check32("overflow_set", io_bus.io_rdata, 32'hD);
    io_bus.io_read = 1'b1;
    wr(8'hFE);
    check32("overflow_set_wins", io_bus.io_rdata, 32'hD);
    #1;
    check32("status_same_cycle", io_bus.io_rdata, 32'hD);
    tick(1);
    io_bus.io_read = 1'b0;
    check32("overflow_cleared", io_bus.io_rdata, 32'h5);
    wait_idle(1000, "drain_fill");

    // 5. reset during data bit 3 of 3C
    sb.push_back(8'h3C);
    wr(8'h3C);
    n = 0;
    do begin @(negedge clk); n++; end while (tx !== 1'b0 && n < 50);
    checks++;
    assert (n < 50) else begin
      errors++; $error("FAIL start_3c: got timeout expected start bit");
    end
    repeat (4 * CPB + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    tick(1);
    check32("abort_tx", {31'd0, tx}, 32'h1);
    check32("abort_status", io_bus.io_rdata, 32'h2);
    @(negedge clk);
    #2 rst_n = 1'b1;
    fs = frames_seen;
    tick(15 * CPB);
    check32("abort_no_frames", frames_seen, fs);
    check32("abort_tx_idle", {31'd0, tx}, 32'h1);

    // 6. last free slot taken while busy; 55 follows after stop + 1 cycle
    sb.push_back(8'h11);
    wr(8'h11);
    n = 0;
    while (tx_busy !== 1'b1 && n < 20) begin tick(1); n++; end
    checks++;
    assert (n < 20) else begin
      errors++; $error("FAIL busy_11: got timeout expected busy");
    end
    for (int b = 8'h12; b <= 8'h18; b++) begin
      sb.push_back(8'(b));
      wr(8'(b));
    end
    check32("one_slot_left", io_bus.io_rdata, 32'h4);
    sb.push_back(8'h55);
    wr(8'h55);
    check32("last_slot_full", io_bus.io_rdata, 32'h5);
    wait_idle(1000, "drain_55");
    check32("final_status", io_bus.io_rdata, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
